// File: rtl/wash_pkg.sv
// Shared wash-machine definitions: controller phase encodings and default phase durations.
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'b000,
    PH_FILL  = 3'b001,
    PH_WASH  = 3'b011,
    PH_RINSE = 3'b111,
    PH_SPIN  = 3'b110
  } phase_e;

  localparam int FILL_SEC_DEF   = 120;
  localparam int WASH_SEC_DEF   = 300;
  localparam int RINSE_SEC_DEF  = 120;
  localparam int SPIN_SEC_DEF   = 60;
  localparam int CLK_FREQ_1_DEF = 1_000_000;

endpackage

// File: rtl/wash_phase_timer_if.sv
// Controller <-> phase timer link: phase/control in, finish/elapsed/tick back.
interface wash_phase_timer_if #(parameter int SEC_W = 9);
  logic [1:0]       clk_freq;
  logic [2:0]       current_state;
  logic             counter_rst_n;
  logic             counter_stop;
  logic             state_finish;
  logic [SEC_W-1:0] elapsed_sec;
  logic             sec_tick;

  modport master (output clk_freq, current_state, counter_rst_n, counter_stop,
                  input  state_finish, elapsed_sec, sec_tick);
  modport slave  (input  clk_freq, current_state, counter_rst_n, counter_stop,
                  output state_finish, elapsed_sec, sec_tick);
endinterface

// File: rtl/wash_sec_prescaler.sv
// Divides clk down to one-second ticks; terminal count follows the live clk_freq.
module wash_sec_prescaler #(
  parameter int CLK_FREQ_1 = 1_000_000,
  parameter int PRESC_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] clk_freq,
  output logic       wrap,
  output logic       sec_tick
);
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] tc;

  always_comb tc = (PRESC_W'(CLK_FREQ_1) << clk_freq) - PRESC_W'(1);

  // >= rather than == so a clk_freq drop below the current count closes the second at once
  assign wrap = en && (presc >= tc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else if (clr) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else if (wrap) begin
      presc    <= '0;
      sec_tick <= 1'b1;
    end else if (en) begin
      presc    <= presc + PRESC_W'(1);
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/wash_phase_timer.sv
// Per-phase seconds timer: counts whole seconds of the current wash phase and flags completion.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int FILL_SEC   = FILL_SEC_DEF,
  parameter int WASH_SEC   = WASH_SEC_DEF,
  parameter int RINSE_SEC  = RINSE_SEC_DEF,
  parameter int SPIN_SEC   = SPIN_SEC_DEF,
  parameter int CLK_FREQ_1 = CLK_FREQ_1_DEF,
  parameter int PRESC_W    = 24,
  parameter int SEC_W      = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  wash_phase_timer_if.slave  bus
);
  localparam int SEC_MAX = (1 << SEC_W) - 1;

  generate
    if (FILL_SEC > SEC_MAX || WASH_SEC > SEC_MAX || RINSE_SEC > SEC_MAX || SPIN_SEC > SEC_MAX)
    begin : g_bad_dur
      $error("wash_phase_timer: phase duration does not fit in SEC_W bits");
    end
    if (longint'(CLK_FREQ_1) * 8 > (longint'(1) << PRESC_W)) begin : g_bad_presc
      $error("wash_phase_timer: PRESC_W too narrow for CLK_FREQ_1 x 8");
    end
  endgenerate

  logic [SEC_W-1:0] dur;
  logic [SEC_W-1:0] elapsed;
  logic [SEC_W:0]   nxt_sec;
  logic             finish;
  logic             clr, en, wrap, tick;

  always_comb begin
    dur = '0;
    case (bus.current_state)
      PH_FILL:  dur = SEC_W'(FILL_SEC);
      PH_WASH:  dur = SEC_W'(WASH_SEC);
      PH_RINSE: dur = SEC_W'(RINSE_SEC);
      PH_SPIN:  dur = SEC_W'(SPIN_SEC);
      default:  dur = '0;
    endcase
  end

  // clear beats hold beats count; a finished phase holds until cleared
  assign clr     = !bus.counter_rst_n || (dur == '0);
  assign en      = !clr && !finish && !bus.counter_stop;
  assign nxt_sec = {1'b0, elapsed} + (SEC_W+1)'(1);

  wash_sec_prescaler #(.CLK_FREQ_1(CLK_FREQ_1), .PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .en       (en),
    .clk_freq (bus.clk_freq),
    .wrap     (wrap),
    .sec_tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed <= '0;
      finish  <= 1'b0;
    end else if (clr) begin
      elapsed <= '0;
      finish  <= 1'b0;
    end else if (wrap) begin
      elapsed <= nxt_sec[SEC_W-1:0];
      if (nxt_sec >= {1'b0, dur}) finish <= 1'b1;
    end
  end

  assign bus.state_finish = finish;
  assign bus.elapsed_sec  = elapsed;
  assign bus.sec_tick     = tick;
endmodule
